// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : draw_sequencer
// Purpose  : Runs one drawing command: clears the screen with the fill engine,
//            then draws a circle with parameters captured at start. Owns the
//            shared VGA plot port, forwards only the active engine's pixels,
//            drops off-screen pixels and counts plotted / clipped pixels.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start / done                    level command handshake
//   centre_x/centre_y/radius/colour circle command, captured on start
//   fill_start/fill_done            fill engine handshake
//   fill_colour_cfg                 constant fill colour
//   fill_x/fill_y/fill_colour/fill_plot   fill pixel stream
//   circ_start/circ_done            circle engine handshake
//   circ_centre_x/circ_centre_y/circ_radius/circ_colour_cfg  captured config
//   circ_x/circ_y/circ_colour/circ_plot   circle pixel stream
//   vga_x/vga_y/vga_colour/vga_plot       registered adapter port
//   plot_count/clip_count           per-command pixel statistics
// ============================================================================
module draw_sequencer #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] FILL_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  radius,
    input  logic [2:0]  colour,
    output logic        fill_start,
    input  logic        fill_done,
    output logic [2:0]  fill_colour_cfg,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic [2:0]  fill_colour,
    input  logic        fill_plot,
    output logic        circ_start,
    input  logic        circ_done,
    output logic [7:0]  circ_centre_x,
    output logic [6:0]  circ_centre_y,
    output logic [7:0]  circ_radius,
    output logic [2:0]  circ_colour_cfg,
    input  logic [7:0]  circ_x,
    input  logic [6:0]  circ_y,
    input  logic [2:0]  circ_colour,
    input  logic        circ_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] plot_count,
    output logic [14:0] clip_count
);

    localparam logic [7:0]  c_X_LIM   = 8'(SCREEN_W);
    localparam logic [6:0]  c_Y_LIM   = 7'(SCREEN_H);
    localparam logic [14:0] c_CNT_MAX = 15'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_FILL_REL = 3'd2,
        S_CIRC     = 3'd3,
        S_CIRC_REL = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_fill_start;
    logic        r_circ_start;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [7:0]  r_rad;
    logic [2:0]  r_col;
    logic [7:0]  r_vga_x;
    logic [6:0]  r_vga_y;
    logic [2:0]  r_vga_col;
    logic        r_vga_plot;
    logic [14:0] r_plot_cnt;
    logic [14:0] r_clip_cnt;

    logic        w_sel_plot;
    logic [7:0]  w_sel_x;
    logic [6:0]  w_sel_y;
    logic [2:0]  w_sel_col;
    logic        w_on_screen;
    logic        w_cmd_go;

    assign w_cmd_go = (r_state == S_IDLE) && start;

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start)      w_next = S_FILL;
            S_FILL:     if (fill_done)  w_next = S_FILL_REL;
            S_FILL_REL: if (!fill_done) w_next = S_CIRC;
            S_CIRC:     if (circ_done)  w_next = S_CIRC_REL;
            S_CIRC_REL: if (!circ_done) w_next = S_DONE;
            S_DONE:     if (!start)     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // Engine starts decode the next state so they are high exactly while the
    // state register holds FILL / CIRC, yet come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_start <= 1'b0;
            r_circ_start <= 1'b0;
        end else begin
            r_fill_start <= (w_next == S_FILL);
            r_circ_start <= (w_next == S_CIRC);
        end
    end

    // ---------------- command capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx  <= 8'd0;
            r_cy  <= 7'd0;
            r_rad <= 8'd0;
            r_col <= 3'd0;
        end else if (w_cmd_go) begin
            r_cx  <= centre_x;
            r_cy  <= centre_y;
            r_rad <= radius;
            r_col <= colour;
        end
    end

    // ---------------- pixel mux and clipping ----------------
    always_comb begin
        w_sel_plot = 1'b0;
        w_sel_x    = 8'd0;
        w_sel_y    = 7'd0;
        w_sel_col  = 3'd0;
        case (r_state)
            S_FILL: begin
                w_sel_plot = fill_plot;
                w_sel_x    = fill_x;
                w_sel_y    = fill_y;
                w_sel_col  = fill_colour;
            end
            S_CIRC: begin
                w_sel_plot = circ_plot;
                w_sel_x    = circ_x;
                w_sel_y    = circ_y;
                w_sel_col  = circ_colour;
            end
            default: ;
        endcase
    end

    assign w_on_screen = (w_sel_x < c_X_LIM) && (w_sel_y < c_Y_LIM);

    // Coordinates/colour only update on a forwarded pixel, so the adapter
    // sees stable values whenever vga_plot is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_x    <= 8'd0;
            r_vga_y    <= 7'd0;
            r_vga_col  <= 3'd0;
            r_vga_plot <= 1'b0;
        end else begin
            r_vga_plot <= w_sel_plot && w_on_screen;
            if (w_sel_plot && w_on_screen) begin
                r_vga_x   <= w_sel_x;
                r_vga_y   <= w_sel_y;
                r_vga_col <= w_sel_col;
            end
        end
    end

    // Counters only move in FILL/CIRC, so clearing in IDLE never collides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plot_cnt <= 15'd0;
            r_clip_cnt <= 15'd0;
        end else if (w_cmd_go) begin
            r_plot_cnt <= 15'd0;
            r_clip_cnt <= 15'd0;
        end else if (w_sel_plot) begin
            if (w_on_screen) begin
                if (r_plot_cnt != c_CNT_MAX) r_plot_cnt <= r_plot_cnt + 15'd1;
            end else begin
                if (r_clip_cnt != c_CNT_MAX) r_clip_cnt <= r_clip_cnt + 15'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign done            = (r_state == S_DONE) && start;
    assign fill_start      = r_fill_start;
    assign circ_start      = r_circ_start;
    assign fill_colour_cfg = FILL_COLOUR;
    assign circ_centre_x   = r_cx;
    assign circ_centre_y   = r_cy;
    assign circ_radius     = r_rad;
    assign circ_colour_cfg = r_col;
    assign vga_x           = r_vga_x;
    assign vga_y           = r_vga_y;
    assign vga_colour      = r_vga_col;
    assign vga_plot        = r_vga_plot;
    assign plot_count      = r_plot_cnt;
    assign clip_count      = r_clip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sequencer
// Purpose  : Self-checking bench for draw_sequencer: a directed vector table
//            for the control path and pixel mux, then full commands driven by
//            behavioural fill / circle engines.
// Revision : 1.0  initial release
// ============================================================================
module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [7:0]  centre_x;
    logic [6:0]  centre_y;
    logic [7:0]  radius;
    logic [2:0]  colour;
    logic        fill_start;
    logic        fill_done;
    logic [2:0]  fill_colour_cfg;
    logic [7:0]  fill_x;
    logic [6:0]  fill_y;
    logic [2:0]  fill_colour;
    logic        fill_plot;
    logic        circ_start;
    logic        circ_done;
    logic [7:0]  circ_centre_x;
    logic [6:0]  circ_centre_y;
    logic [7:0]  circ_radius;
    logic [2:0]  circ_colour_cfg;
    logic [7:0]  circ_x;
    logic [6:0]  circ_y;
    logic [2:0]  circ_colour;
    logic        circ_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [14:0] plot_count;
    logic [14:0] clip_count;

    int n_checks = 0;
    int n_err    = 0;

    draw_sequencer #(.SCREEN_W(160), .SCREEN_H(120), .FILL_COLOUR(3'b000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
        .fill_start(fill_start), .fill_done(fill_done), .fill_colour_cfg(fill_colour_cfg),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_done(circ_done),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius), .circ_colour_cfg(circ_colour_cfg),
        .circ_x(circ_x), .circ_y(circ_y), .circ_colour(circ_colour), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .plot_count(plot_count), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n, start, fd, cd, fp;
        logic [7:0]  fx;
        logic [6:0]  fy;
        logic        cp;
        logic [7:0]  cx;
        logic [6:0]  cy;
        logic        efs, ecs, edn, evp;
        logic [7:0]  evx;
        logic [6:0]  evy;
        logic [2:0]  evc;
        logic [14:0] epc, ecc;
    } vec_t;

    vec_t tbl[20];

    // ---------------- circle model ----------------
    typedef struct packed { logic [7:0] x; logic [6:0] y; } pt_t;
    pt_t cq[$];

    function automatic void add_pt(input int x, input int y);
        pt_t p;
        if (x >= 0 && x < 256 && y >= 0 && y < 128) begin
            p.x = 8'(x);
            p.y = 7'(y);
            cq.push_back(p);
        end
    endfunction

    function automatic void build_circle(input int cx, input int cy, input int r);
        int ox, oy, crit;
        cq.delete();
        ox = r; oy = 0; crit = 1 - r;
        while (oy <= ox) begin
            add_pt(cx + ox, cy + oy); add_pt(cx + oy, cy + ox);
            add_pt(cx - ox, cy + oy); add_pt(cx - oy, cy + ox);
            add_pt(cx - ox, cy - oy); add_pt(cx - oy, cy - ox);
            add_pt(cx + ox, cy - oy); add_pt(cx + oy, cy - ox);
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endfunction

    task automatic engines_idle();
        fill_done = 0; fill_plot = 0; fill_x = 0; fill_y = 0; fill_colour = 0;
        circ_done = 0; circ_plot = 0; circ_x = 0; circ_y = 0; circ_colour = 0;
    endtask

    // Full command with behavioural engines. perturb: change centre_x during
    // fill and inject a stray circle plot. abort_at >= 0: reset after that
    // many fill pixels.
    int exp_plot, exp_clip;
    task automatic run_cmd(input int cx, input int cy, input int r, input logic [2:0] col,
                           input bit perturb, input int abort_at);
        int fidx, cidx;
        bit p_valid, seen_fill, seen_circ;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        build_circle(cx, cy, r);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = col;
        engines_idle();
        start = 1;
        fidx = 0; cidx = 0; exp_plot = 0; exp_clip = 0;
        p_valid = 0; seen_fill = 0; seen_circ = 0; px = 0; py = 0; pc = 0;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(posedge clk); #1;
            chk("vga_plot", cyc, vga_plot, p_valid);
            if (p_valid) begin
                chk("vga_x", cyc, vga_x, px);
                chk("vga_y", cyc, vga_y, py);
                chk("vga_colour", cyc, vga_colour, pc);
            end
            chk("start_overlap", cyc, fill_start & circ_start, 0);
            if (fill_start) seen_fill = 1;
            if (circ_start && !seen_circ) begin
                seen_circ = 1;
                chk("fill_before_circ", cyc, seen_fill, 1);
                chk("circ_centre_x", cyc, circ_centre_x, cx);
                chk("circ_centre_y", cyc, circ_centre_y, cy);
                chk("circ_radius", cyc, circ_radius, r);
                chk("circ_colour_cfg", cyc, circ_colour_cfg, col);
            end
            if (done) break;
            if (abort_at >= 0 && fidx == abort_at) begin
                rst_n = 0;
                #1;
                chk("abort_fill_start", fidx, fill_start, 0);
                chk("abort_plot_count", fidx, plot_count, 0);
                chk("abort_vga_plot", fidx, vga_plot, 0);
                chk("abort_circ_centre_x", fidx, circ_centre_x, 0);
                engines_idle();
                start = 0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                return;
            end
            // fill engine: raster scan, then done until released
            if (!fill_start) begin
                fill_done = 0; fill_plot = 0; fidx = 0;
            end else if (fidx < 19200) begin
                fill_x = 8'(fidx % 160); fill_y = 7'(fidx / 160);
                fill_colour = 3'b000; fill_plot = 1; fidx++;
            end else begin
                fill_plot = 0; fill_done = 1;
            end
            // circle engine: replay model points, then done until released
            if (!circ_start) begin
                circ_done = 0; circ_plot = 0; cidx = 0;
            end else if (cidx < cq.size()) begin
                circ_x = cq[cidx].x; circ_y = cq[cidx].y;
                circ_colour = col; circ_plot = 1; cidx++;
            end else begin
                circ_plot = 0; circ_done = 1;
            end
            // expectation for the next cycle from legitimate pixels only
            p_valid = 0;
            if (fill_plot || circ_plot) begin
                px = fill_plot ? fill_x : circ_x;
                py = fill_plot ? fill_y : circ_y;
                pc = fill_plot ? fill_colour : circ_colour;
                if (px < 8'd160 && py < 7'd120) begin
                    p_valid = 1; exp_plot++;
                end else exp_clip++;
            end
            if (perturb && fidx == 100) centre_x = 8'd10;
            if (perturb && fidx == 200 && fill_start) begin
                circ_plot = 1; circ_x = 8'd5; circ_y = 7'd5; circ_colour = 3'b111;
            end
        end
        chk("cmd_done", 0, done, 1);
        chk("plot_count", 0, plot_count, exp_plot);
        chk("clip_count", 0, clip_count, exp_clip);
        chk("pixel_total", 0, 32'(plot_count) + 32'(clip_count), 19200 + cq.size());
        chk("circ_centre_x_end", 0, circ_centre_x, cx);
        engines_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("done_hold", i, done, 1);
        end
        start = 0;
        #1;
        chk("done_drop_comb", 0, done, 0);
        @(posedge clk); #1;
        chk("done_after_drop", 0, done, 0);
        chk("idle_fill_start", 0, fill_start, 0);
        chk("count_hold", 0, plot_count, exp_plot);
    endtask

    initial begin
        rst_n = 0; start = 0;
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'b010;
        engines_idle();

        //          rst st fd cd fp  fx   fy  cp  cx  cy | fs cs dn vp  vx   vy  vc pc cc
        tbl[0]  = '{0, 0, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,   0,   0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,   0,   0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0,   0,   0, 0,  0,  0,  1, 0, 0, 0,   0,   0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 1,  10,  20, 0,  0,  0,  1, 0, 0, 1,  10,  20, 5, 1, 0};
        tbl[4]  = '{1, 1, 0, 0, 1, 160,   0, 0,  0,  0,  1, 0, 0, 0,  10,  20, 5, 1, 1};
        tbl[5]  = '{1, 1, 0, 0, 1, 159, 119, 0,  0,  0,  1, 0, 0, 1, 159, 119, 5, 2, 1};
        tbl[6]  = '{1, 1, 0, 0, 1,   0, 120, 0,  0,  0,  1, 0, 0, 0, 159, 119, 5, 2, 2};
        tbl[7]  = '{1, 1, 0, 0, 0,   0,   0, 1,  5,  5,  1, 0, 0, 0, 159, 119, 5, 2, 2};
        tbl[8]  = '{1, 1, 1, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0, 159, 119, 5, 2, 2};
        tbl[9]  = '{1, 1, 1, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0, 159, 119, 5, 2, 2};
        tbl[10] = '{1, 1, 0, 0, 0,   0,   0, 0,  0,  0,  0, 1, 0, 0, 159, 119, 5, 2, 2};
        tbl[11] = '{1, 1, 0, 0, 1,   1,   1, 0,  0,  0,  0, 1, 0, 0, 159, 119, 5, 2, 2};
        tbl[12] = '{1, 1, 0, 0, 0,   0,   0, 1, 80, 60,  0, 1, 0, 1,  80,  60, 3, 3, 2};
        tbl[13] = '{1, 1, 0, 1, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,  80,  60, 3, 3, 2};
        tbl[14] = '{1, 1, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 1, 0,  80,  60, 3, 3, 2};
        tbl[15] = '{1, 1, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 1, 0,  80,  60, 3, 3, 2};
        tbl[16] = '{1, 0, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,  80,  60, 3, 3, 2};
        tbl[17] = '{1, 0, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,  80,  60, 3, 3, 2};
        tbl[18] = '{1, 1, 0, 0, 0,   0,   0, 0,  0,  0,  1, 0, 0, 0,  80,  60, 3, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 0,   0,   0, 0,  0,  0,  0, 0, 0, 0,   0,   0, 0, 0, 0};

        // reset state, then idle for 10 cycles after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vga_plot", 0, vga_plot, 0);
        chk("rst_fill_start", 0, fill_start, 0);
        chk("rst_circ_centre_x", 0, circ_centre_x, 0);
        chk("rst_plot_count", 0, plot_count, 0);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_outputs", i, {fill_start, circ_start, done, vga_plot, vga_x,
                                    plot_count, clip_count}, 0);
        end

        // control path and mux vectors
        fill_colour = 3'b101; circ_colour = 3'b011;
        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst_n; start = tbl[i].start;
            fill_done = tbl[i].fd; circ_done = tbl[i].cd;
            fill_plot = tbl[i].fp; fill_x = tbl[i].fx; fill_y = tbl[i].fy;
            circ_plot = tbl[i].cp; circ_x = tbl[i].cx; circ_y = tbl[i].cy;
            @(posedge clk); #1;
            chk("v_fill_start", i, fill_start, tbl[i].efs);
            chk("v_circ_start", i, circ_start, tbl[i].ecs);
            chk("v_done", i, done, tbl[i].edn);
            chk("v_vga_plot", i, vga_plot, tbl[i].evp);
            chk("v_vga_x", i, vga_x, tbl[i].evx);
            chk("v_vga_y", i, vga_y, tbl[i].evy);
            chk("v_vga_colour", i, vga_colour, tbl[i].evc);
            chk("v_plot_count", i, plot_count, tbl[i].epc);
            chk("v_clip_count", i, clip_count, tbl[i].ecc);
            if (i == 2) begin
                chk("v_cfg_cx", i, circ_centre_x, 80);
                chk("v_cfg_cy", i, circ_centre_y, 60);
                chk("v_cfg_r", i, circ_radius, 40);
                chk("v_cfg_col", i, circ_colour_cfg, 2);
                chk("v_fill_cfg", i, fill_colour_cfg, 0);
            end
        end
        chk("v_rst_cfg_cx", 0, circ_centre_x, 0);
        rst_n = 1; start = 0;
        engines_idle();
        repeat (2) @(posedge clk);

        // full command with config change and stray plot during fill
        run_cmd(80, 60, 40, 3'b010, 1'b1, -1);
        chk("t2_clip_zero", 0, clip_count, 0);
        chk("t2_plot_total", 0, plot_count, 19200 + cq.size());
        repeat (2) @(posedge clk);

        // clipping command near the bottom-right corner
        run_cmd(150, 110, 30, 3'b110, 1'b0, -1);
        chk("t3_clip_nonzero", 0, clip_count != 0, 1);
        repeat (2) @(posedge clk);

        // reset mid-fill, then a fresh command
        run_cmd(80, 60, 40, 3'b010, 1'b0, 5000);
        repeat (2) @(posedge clk);
        run_cmd(80, 60, 40, 3'b010, 1'b0, -1);
        chk("t6_plot_total", 0, plot_count, 19200 + cq.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
